// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU definitions.
//  state_t  : reader FSM states (CAPT2 is only reachable with the wait feature)
//  sat_max  : all-ones value for an N-bit saturating counter
package elixirchip_es1_spu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_CAPT2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [31:0] sat_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_sat_counter.sv
// Saturating up-counter.
//  clk, reset_n : clock, synchronous active-low reset (count -> 0)
//  inc          : count one event (ignored once saturated)
//  clear        : restart; with inc in the same cycle the count restarts at 1
//  count        : current value
//  sat          : count is at 2**CNT_BITS-1
module elixirchip_es1_spu_sat_counter
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                inc,
  input  logic                clear,
  output logic [CNT_BITS-1:0] count,
  output logic                sat
);

  localparam logic [CNT_BITS-1:0] MAX = CNT_BITS'(sat_max(CNT_BITS));

  assign sat = (count == MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? CNT_BITS'(1) : '0;
    end else if (inc && !sat) begin
      count <= count + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_reg_reader.sv
// Host-side read port for an SPU register op: on request, takes a snapshot of
// r_data together with the number of register updates seen since the previous
// capture. Free-running on clk; r_data/r_update are only looked at when cke=1.
//  clk, reset_n     : clock, synchronous active-low reset
//  cke, r_data,
//  r_update         : observed register (cke-gated SPU domain)
//  s_wait           : request qualifier, wait for the next update
//  s_valid/s_ready  : request handshake (one request outstanding at a time)
//  m_data, m_count,
//  m_ovf            : snapshot, updates since last capture, counter saturated
//  m_valid/m_ready  : response handshake
// Optional feature macro: ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
//  defined   -> s_wait latched at accept; s_wait=1 captures the post-update value
//  undefined -> s_wait ignored; capture on the first cke=1 edge
module elixirchip_es1_spu_op_reg_reader
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter int  CNT_BITS   = 4,
  parameter data_t CLEAR_DATA = '1,
  parameter      DEVICE     = "RTL",
  parameter      SIMULATION = "false",
  parameter      DEBUG      = "false"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cke,
  input  data_t               r_data,
  input  logic                r_update,
  input  logic                s_wait,
  input  logic                s_valid,
  output logic                s_ready,
  output data_t               m_data,
  output logic [CNT_BITS-1:0] m_count,
  output logic                m_ovf,
  output logic                m_valid,
  input  logic                m_ready
);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                cnt_sat;
  logic                upd;
  logic                capture;

  assign upd = cke & r_update;

`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
  logic wait_lat;

  // With wait latched, CAPT only arms on an update; the capture itself is in
  // CAPT2 on the following cke edge so the post-update value is sampled.
  always_comb begin
    capture = cke & (((state == ST_CAPT) & ~wait_lat) | (state == ST_CAPT2));
  end
`else
  logic unused_s_wait;
  assign unused_s_wait = s_wait;

  always_comb begin
    capture = cke & (state == ST_CAPT);
  end
`endif

  // An update on the capture edge restarts the count at 1 for the next read.
  elixirchip_es1_spu_sat_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (upd),
    .clear   (capture),
    .count   (cnt),
    .sat     (cnt_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= CLEAR_DATA;
      m_count <= '0;
      m_ovf   <= 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
      wait_lat <= 1'b0;
`endif
    end else begin
      if (capture) begin
        m_data  <= r_data;
        m_count <= cnt;
        m_ovf   <= cnt_sat;
      end
      unique case (state)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            state   <= ST_CAPT;
            s_ready <= 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
            wait_lat <= s_wait;
`endif
          end else begin
            s_ready <= 1'b1;
          end
        end
        ST_CAPT: begin
          if (capture) begin
            state   <= ST_RESP;
            m_valid <= 1'b1;
          end
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
          else if (upd) begin
            state <= ST_CAPT2;
          end
`endif
        end
        ST_CAPT2: begin
          if (capture) begin
            state   <= ST_RESP;
            m_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (m_ready) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  localparam bit CHECK_EN = (|DEVICE) && (SIMULATION != "false") && (DEBUG != "false");

  generate
    if (CHECK_EN) begin : g_check
      always_ff @(posedge clk) begin
        if (reset_n) begin
          assert (!(m_valid && s_ready));
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_reg_reader.sv
module tb_elixirchip_es1_spu_op_reg_reader;

  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       reset_n, cke, r_update, s_wait, s_valid, m_ready;
  logic [7:0] r_data;
  logic       s_ready, m_ovf, m_valid;
  logic [7:0] m_data;
  logic [3:0] m_count;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_reg_reader #(
    .DATA_BITS (8),
    .CNT_BITS  (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cke      (cke),
    .r_data   (r_data),
    .r_update (r_update),
    .s_wait   (s_wait),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_count  (m_count),
    .m_ovf    (m_ovf),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] data; int cnt; bit ovf; } resp_t;
  resp_t sb[$];

  localparam int P_IDLE = 0, P_WAITCAP = 1, P_WAITUPD = 2, P_ARMED = 3, P_RESP = 4;
  int phase       = P_IDLE;
  int upd_since   = 0;   // unbounded; saturation applied when a response is formed
  bit exp_sready  = 1'b0;
  bit exp_mvalid  = 1'b0;

  function automatic resp_t make_resp(input logic [7:0] d, input int n);
    resp_t r;
    r.data = d;
    r.cnt  = (n > MAXC) ? MAXC : n;
    r.ovf  = (n >= MAXC);
    return r;
  endfunction

  always @(posedge clk) begin
    bit u;
    bit took;
    u = cke && r_update;
    took = 1'b0;
    if (!reset_n) begin
      phase = P_IDLE; upd_since = 0; exp_sready = 1'b0; exp_mvalid = 1'b0;
      sb.delete();
    end else begin
      case (phase)
        P_IDLE: begin
          if (s_valid && exp_sready) begin
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
            phase = s_wait ? P_WAITUPD : P_WAITCAP;
`else
            phase = P_WAITCAP;
`endif
            exp_sready = 1'b0;
          end else begin
            exp_sready = 1'b1;
          end
        end
        P_WAITCAP, P_ARMED: begin
          if (cke) begin
            sb.push_back(make_resp(r_data, upd_since));
            upd_since = u ? 1 : 0;
            took = 1'b1;
            phase = P_RESP;
            exp_mvalid = 1'b1;
          end
        end
        P_WAITUPD: if (u) phase = P_ARMED;
        P_RESP: begin
          if (m_ready) begin
            phase = P_IDLE; exp_mvalid = 1'b0; exp_sready = 1'b1;
          end
        end
        default: ;
      endcase
      if (!took && u) upd_since++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    chk("s_ready", {31'd0, s_ready}, {31'd0, exp_sready});
    chk("m_valid", {31'd0, m_valid}, {31'd0, exp_mvalid});
    if (m_valid) begin
      if (sb.size() == 0) begin
        chk("sb_has_entry", 32'(sb.size()), 32'd1);
      end else begin
        chk("m_data",  {24'd0, m_data},  {24'd0, sb[0].data});
        chk("m_count", {28'd0, m_count}, 32'(sb[0].cnt));
        chk("m_ovf",   {31'd0, m_ovf},   {31'd0, sb[0].ovf});
        if (m_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request();
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (s_ready) done = 1'b1;
      step();
    end
    s_valid = 1'b0;
    if (!done) chk("request_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cke = 1'b1; r_data = 8'h00; r_update = 1'b0;
    s_wait = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

    // reset
    repeat (3) step();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data",  {24'd0, m_data},  32'hFF);
    chk("rst_m_count", {28'd0, m_count}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("s_ready_after_release", {31'd0, s_ready}, 32'd1);

    // single read, minimum latency
    r_data = 8'h5A;
    request();
    chk("no_valid_at_accept", {31'd0, m_valid}, 32'd0);
    step();
    chk("lat1_valid", {31'd0, m_valid}, 32'd1);
    chk("lat1_data",  {24'd0, m_data},  32'h5A);
    chk("lat1_count", {28'd0, m_count}, 32'd0);
    chk("lat1_ovf",   {31'd0, m_ovf},   32'd0);
    handshake();

    // cke held low stalls the capture
    request();
    cke = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_valid", {31'd0, m_valid}, 32'd0);
    end
    cke = 1'b1; r_data = 8'h3C;
    step();
    chk("stall_valid", {31'd0, m_valid}, 32'd1);
    chk("stall_data",  {24'd0, m_data},  32'h3C);
    handshake();

    // saturation
    r_update = 1'b1;
    repeat (20) step();
    r_update = 1'b0;
    request();
    step();
    chk("sat_count", {28'd0, m_count}, 32'd15);
    chk("sat_ovf",   {31'd0, m_ovf},   32'd1);
    handshake();
    request();
    step();
    chk("post_sat_count", {28'd0, m_count}, 32'd0);
    chk("post_sat_ovf",   {31'd0, m_ovf},   32'd0);
    handshake();

    // update on the capture edge
    r_data = 8'h11;
    request();
    r_update = 1'b1;
    step();
    chk("coinc_data", {24'd0, m_data}, 32'h11);
    r_update = 1'b0; r_data = 8'h22;
    handshake();
    request();
    step();
    chk("coinc_next_count", {28'd0, m_count}, 32'd1);
    chk("coinc_next_data",  {24'd0, m_data},  32'h22);

    // hold response with m_ready low, then reset in RESP
    repeat (4) step();
    chk("held_valid", {31'd0, m_valid}, 32'd1);
    chk("held_data",  {24'd0, m_data},  32'h22);
    reset_n = 1'b0;
    step();
    chk("rst_in_resp_valid", {31'd0, m_valid}, 32'd0);
    reset_n = 1'b1;
    step();

`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_READER_WAIT_EN
    r_data = 8'h40;
    s_wait = 1'b1;
    request();
    s_wait = 1'b0;
    repeat (6) step();
    chk("wait_no_valid", {31'd0, m_valid}, 32'd0);
    r_update = 1'b1;
    step();
    r_update = 1'b0; r_data = 8'h41;
    chk("wait_not_yet", {31'd0, m_valid}, 32'd0);
    step();
    chk("wait_valid", {31'd0, m_valid}, 32'd1);
    chk("wait_data",  {24'd0, m_data},  32'h41);
    chk("wait_count", {28'd0, m_count}, 32'd1);
    handshake();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cke      = ($urandom_range(0, 9) != 0);
      r_update = ($urandom_range(0, 9) < 3);
      r_data   = 8'($urandom);
      s_wait   = ($urandom_range(0, 3) == 0);
      s_valid  = ($urandom_range(0, 1) == 1);
      m_ready  = ($urandom_range(0, 9) < 6);
      reset_n  = ($urandom_range(0, 199) != 0);
      step();
    end

    // drain
    reset_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1; cke = 1'b1; r_update = 1'b0;
    repeat (10) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
